// File: rtl/pic_wr_pkg.sv
// Shared types and default sizing for the picture-RAM write path.
package pic_wr_pkg;

  localparam int unsigned PIC_SIZE    = 10000;
  localparam int unsigned ADDR_W      = 14;
  localparam int unsigned TIMEOUT_CYC = 25000;

  typedef enum logic {
    S_HI = 1'b0,
    S_LO = 1'b1
  } state_e;

endpackage

// File: rtl/pic_wr_gap_timer.sv
// Counts cycles since the last byte strobe and saturates at TIMEOUT_CYC-1.
// Used only when PIC_WR_TIMEOUT_EN is defined.
module pic_wr_gap_timer #(
  parameter int unsigned TIMEOUT_CYC = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // expired is registered alongside the count so it always equals (cnt_q == LAST)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == LAST);
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/pic_ram_wr.sv
// Assembles RGB565 pixels from a byte stream and writes them to the picture RAM.
// Optional inter-byte timeout resync is enabled by defining PIC_WR_TIMEOUT_EN.
module pic_ram_wr #(
  parameter int unsigned PIC_SIZE    = pic_wr_pkg::PIC_SIZE,
  parameter int unsigned ADDR_W      = pic_wr_pkg::ADDR_W,
  parameter int unsigned TIMEOUT_CYC = pic_wr_pkg::TIMEOUT_CYC
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_flag,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              busy,
  output logic              err
);

  import pic_wr_pkg::state_e;
  import pic_wr_pkg::S_HI;
  import pic_wr_pkg::S_LO;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIC_SIZE - 1);

  if (TIMEOUT_CYC < 2 || PIC_SIZE < 1 || PIC_SIZE > (2 ** ADDR_W)) begin : g_param_check
    $error("pic_ram_wr: illegal PIC_SIZE/ADDR_W/TIMEOUT_CYC");
  end

  state_e            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              expire_c;

`ifdef PIC_WR_TIMEOUT_EN
  logic gap_expired;

  pic_wr_gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_timer (
    .clk     (vga_clk),
    .rst_n   (sys_rst_n),
    .clr     (rx_flag),
    .expired (gap_expired)
  );

  // A strobe in the expiry cycle takes priority over the resync
  assign expire_c = gap_expired && busy_q && !rx_flag;
`else
  assign expire_c = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    cnt_d        = cnt_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;

    if (rx_flag) begin
      case (state_q)
        S_HI: begin
          hi_d    = rx_data;
          state_d = S_LO;
        end
        default: begin
          state_d      = S_HI;
          wr_en_d      = 1'b1;
          wr_addr_d    = cnt_q;
          wr_data_d    = {hi_q, rx_data};
          frame_done_d = (cnt_q == LAST_ADDR);
          cnt_d        = (cnt_q == LAST_ADDR) ? '0 : cnt_q + ADDR_W'(1);
        end
      endcase
    end else if (expire_c) begin
      state_d = S_HI;
      cnt_d   = '0;
      err_d   = 1'b1;
    end

    busy_d = (state_d == S_LO) || (cnt_d != '0);
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_HI;
      hi_q         <= 8'h00;
      cnt_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 16'h0000;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      cnt_q        <= cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pic_ram_wr.sv
// Self-checking bench for pic_ram_wr: directed vector table, corner sequences,
// and random byte streams checked against a byte-count reference model.
module tb_pic_ram_wr;

  localparam int unsigned PIC = 10000;
  localparam int unsigned AW  = 14;
  localparam int unsigned TO  = 40;
`ifdef PIC_WR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef logic [AW+19:0] obs_t;

  logic          vga_clk = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_flag = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          frame_done;
  logic          busy;
  logic          err;

  always #5 vga_clk = ~vga_clk;

  pic_ram_wr #(
    .PIC_SIZE    (PIC),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .vga_clk    (vga_clk),
    .sys_rst_n  (sys_rst_n),
    .rx_data    (rx_data),
    .rx_flag    (rx_flag),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .busy       (busy),
    .err        (err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: position in the frame measured in bytes received
  int          byte_cnt = 0;
  int          idle     = 0;
  logic [7:0]  m_hi     = 8'h00;
  logic        e_wr = 1'b0, e_fd = 1'b0, e_busy = 1'b0, e_err = 1'b0;
  int          e_addr = 0;
  logic [15:0] e_data = 16'h0000;

  typedef struct {
    logic        f;
    logic [7:0]  d;
    logic        wr;
    int          addr;
    logic [15:0] data;
    logic        fd;
    logic        busy;
  } vec_t;

  vec_t tbl [10];

  function automatic obs_t dut_obs();
    return {wr_en, wr_addr, wr_data, frame_done, busy, err};
  endfunction

  function automatic obs_t mk_obs(logic w, int a, logic [15:0] d, logic f, logic b, logic e);
    return {w, AW'(a), d, f, b, e};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got {wr,addr,data,fd,busy,err}=%h required %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // One clock of stimulus; advances the model and samples #1 after the edge
  task automatic tick(input logic f, input logic [7:0] d);
    rx_flag = f;
    rx_data = d;
    e_wr  = 1'b0;
    e_fd  = 1'b0;
    e_err = 1'b0;
    if (f) begin
      if (byte_cnt % 2 == 1) begin
        e_wr     = 1'b1;
        e_addr   = byte_cnt / 2;
        e_data   = {m_hi, d};
        e_fd     = (e_addr == PIC - 1);
        byte_cnt = (byte_cnt + 1) % (2 * PIC);
      end else begin
        m_hi     = d;
        byte_cnt = byte_cnt + 1;
      end
      idle = 0;
    end else begin
      if (TO_EN && idle == TO - 1 && byte_cnt != 0) begin
        e_err    = 1'b1;
        byte_cnt = 0;
      end
      if (idle < TO - 1) idle++;
    end
    e_busy = (byte_cnt != 0);
    @(posedge vga_clk);
    #1;
    rx_flag = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic tick_chk(input logic f, input logic [7:0] d, input string name);
    tick(f, d);
    check(name, dut_obs(), mk_obs(e_wr, e_addr, e_data, e_fd, e_busy, e_err));
  endtask

  task automatic do_reset();
    rx_flag   = 1'b0;
    sys_rst_n = 1'b0;
    #3;
    check("reset_outputs", dut_obs(), '0);
    @(posedge vga_clk);
    #1;
    sys_rst_n = 1'b1;
    byte_cnt = 0;
    idle     = 0;
    m_hi     = 8'h00;
    e_wr = 1'b0; e_fd = 1'b0; e_busy = 1'b0; e_err = 1'b0;
    e_addr = 0;
    e_data = 16'h0000;
  endtask

  initial begin
    int errs, wrs, nwr, nfd, bad;

    tbl[0] = '{1'b1, 8'hF8, 1'b0, 0, 16'h0000, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h3C, 1'b0, 0, 16'h0000, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'h00, 1'b1, 0, 16'hF800, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'hAA, 1'b0, 0, 16'hF800, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'h12, 1'b0, 0, 16'hF800, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'h34, 1'b1, 1, 16'h1234, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h55, 1'b0, 1, 16'h1234, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 8'h07, 1'b0, 1, 16'h1234, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 8'hE0, 1'b1, 2, 16'h07E0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 8'h99, 1'b0, 2, 16'h07E0, 1'b0, 1'b1};

    #1;
    do_reset();

    // Directed vectors: isolated strobes, back-to-back pair, ignored data
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].f, tbl[i].d);
      check($sformatf("vec%0d", i), dut_obs(),
            mk_obs(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].fd, tbl[i].busy, 1'b0));
    end

    // Reset after 3 pixels + 1 byte discards the partial pixel
    tick_chk(1'b1, 8'hAB, "pre_reset_byte");
    do_reset();
    tick_chk(1'b1, 8'hFF, "post_reset_hi");
    tick_chk(1'b1, 8'hFF, "post_reset_lo");
    check("post_reset_pixel", dut_obs(), mk_obs(1'b1, 0, 16'hFFFF, 1'b0, 1'b1, 1'b0));

    // Idle gap after a high byte
    do_reset();
    tick_chk(1'b1, 8'h07, "gap_hi");
    errs = 0;
    wrs  = 0;
    for (int k = 0; k < TO + 3; k++) begin
      tick_chk(1'b0, 8'($urandom), "gap_idle");
      errs += int'(err);
      wrs  += int'(wr_en);
    end
    check_int("gap_err_pulses", errs, TO_EN ? 1 : 0);
    check_int("gap_writes", wrs, 0);
    if (TO_EN) tick(1'b1, 8'h07);
    tick_chk(1'b1, 8'hE0, "gap_resume");
    check("gap_pixel", dut_obs(), mk_obs(1'b1, 0, 16'h07E0, 1'b0, 1'b1, 1'b0));

    // Strobe coincident with timer expiry at address 5 in S_LO
    do_reset();
    for (int k = 0; k < 10; k++) tick_chk(1'b1, 8'($urandom), "pre5");
    tick_chk(1'b1, 8'h5A, "addr5_hi");
    for (int k = 0; k < TO - 1; k++) tick_chk(1'b0, 8'($urandom), "addr5_idle");
    tick_chk(1'b1, 8'hC3, "addr5_lo");
    check("expiry_strobe_wins", dut_obs(), mk_obs(1'b1, 5, 16'h5AC3, 1'b0, 1'b1, 1'b0));

    // Full frame of back-to-back bytes
    do_reset();
    nwr = 0;
    nfd = 0;
    bad = 0;
    for (int k = 0; k < 2 * PIC; k++) begin
      tick_chk(1'b1, 8'($urandom), "frame");
      if (wr_en) begin
        if (int'(wr_addr) != nwr) bad++;
        if (frame_done && int'(wr_addr) != PIC - 1) bad++;
        nwr++;
      end
      if (frame_done) nfd++;
    end
    check_int("frame_writes", nwr, PIC);
    check_int("frame_done_count", nfd, 1);
    check_int("frame_order_errors", bad, 0);
    check_int("frame_busy_after", int'(busy), 0);
    tick_chk(1'b1, 8'h12, "wrap_hi");
    tick_chk(1'b1, 8'h34, "wrap_lo");
    check("wrap_pixel", dut_obs(), mk_obs(1'b1, 0, 16'h1234, 1'b0, 1'b1, 1'b0));

    // Random strobes with occasional long gaps
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 2) begin
        for (int j = 0; j < TO + 5; j++) tick_chk(1'b0, 8'($urandom), "rand_gap");
      end else begin
        tick_chk(($urandom_range(0, 2) != 0), 8'($urandom), "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_ram_wr.md
PIC_RAM_WR -- requirements
Module: pic_ram_wr

Interface
REQ-001 Parameter PIC_SIZE, default 10000, meaning pixels per frame (100x100 picture).
REQ-002 Parameter ADDR_W, default 14, meaning wr_addr width.
REQ-003 Parameter TIMEOUT_CYC, default 25000, meaning idle cycles between bytes before resync.
REQ-004 vga_clk  input  1  clock; all logic on its rising edge.
REQ-005 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rx_data  input  8  received byte, valid only while rx_flag=1.
REQ-007 rx_flag  input  1  single-cycle byte strobe.
REQ-008 wr_en  output  1  RAM write strobe, one cycle per pixel.
REQ-009 wr_addr  output  ADDR_W  RAM write address, 0..PIC_SIZE-1.
REQ-010 wr_data  output  16  RGB565 pixel, {high byte, low byte}.
REQ-011 frame_done  output  1  one-cycle pulse on the final pixel write of a frame.
REQ-012 busy  output  1  high while a frame or pixel is partially received.
REQ-013 err  output  1  one-cycle pulse on timeout resync (0 when feature compiled out).

Function
REQ-014 SHALL use a 2-state FSM: S_HI (awaiting high byte), S_LO (awaiting low byte).
REQ-015 S_HI + rx_flag: SHALL latch rx_data as the high byte and go to S_LO; no write.
REQ-016 S_LO + rx_flag: SHALL go to S_HI and, on the next cycle, assert wr_en=1 with wr_data={hi,rx_data} and wr_addr=pixel counter.
REQ-017 Latency from low-byte rx_flag to wr_en SHALL be exactly 1 cycle; wr_en, wr_addr and wr_data SHALL be registered.
REQ-018 Pixel counter SHALL increment by 1 after each write; after writing address PIC_SIZE-1 it SHALL wrap to 0.
REQ-019 frame_done SHALL be asserted in the same cycle as the wr_en for address PIC_SIZE-1.
REQ-020 wr_addr and wr_data SHALL hold their last values while wr_en=0.
REQ-021 busy SHALL equal (state==S_LO) OR (pixel counter != 0), registered.
REQ-022 Back-to-back rx_flag on consecutive cycles SHALL be accepted without loss; throughput is one pixel per two strobes.
REQ-023 rx_data SHALL be ignored when rx_flag=0.

Reset
REQ-024 On sys_rst_n=0: state=S_HI, counter=0, hi byte=0, wr_en=0, wr_addr=0, wr_data=16'h0000, frame_done=0, busy=0, err=0, gap timer=0.
REQ-025 Reset asserted mid-frame or mid-pixel SHALL discard partial data; the first byte after release is a high byte for address 0.

Configuration
REQ-026 Macro PIC_WR_TIMEOUT_EN defined: gap timer counts cycles since last rx_flag, cleared on rx_flag, saturating at TIMEOUT_CYC-1.
REQ-027 With PIC_WR_TIMEOUT_EN, when the timer reaches TIMEOUT_CYC-1 and busy=1: state->S_HI, counter->0, err pulses 1 cycle, no write.
REQ-028 With PIC_WR_TIMEOUT_EN, rx_flag in the expiry cycle SHALL win: byte processed normally, no err.
REQ-029 Macro undefined: no gap timer logic, err tied 0, partial frames persist indefinitely.

Structure
REQ-030 Shared package pic_wr_pkg SHALL hold the FSM state typedef (S_HI, S_LO) and default constants PIC_SIZE, ADDR_W, TIMEOUT_CYC.
REQ-031 Gap timer SHALL be a sub-module pic_wr_gap_timer (inputs clk, rst_n, clr, outputs expired), instantiated only under PIC_WR_TIMEOUT_EN.
REQ-032 Write port SHALL connect directly to the write side of the dual-port picture RAM read by the VGA pixel generator.

Verification
REQ-033 Bytes 0xF8,0x00 on isolated strobes -> one wr_en, wr_addr=0, wr_data=16'hF800, 1 cycle after second strobe.
REQ-034 20000 back-to-back bytes -> 10000 writes, addresses 0..9999 in order, frame_done only with addr 9999, then counter=0 and busy=0.
REQ-035 Send 0x07 then idle TIMEOUT_CYC cycles (macro defined) -> err one pulse, no wr_en, next pair 0x07,0xE0 writes 16'h07E0 at addr 0.
REQ-036 Same idle with macro undefined -> err stays 0, next byte 0xE0 completes pixel 16'h07E0 at addr 0.
REQ-037 sys_rst_n pulsed low after 3 pixels + 1 byte -> all outputs 0; next pair 0xFF,0xFF writes 16'hFFFF at addr 0.
REQ-038 rx_flag coincident with timer expiry at addr 5 in S_LO -> pixel written at addr 5, err=0.
